// File: rtl/cbus_mem_responder.sv
// Cache-bus worker: serves FIXED/INCR/WRAP bursts out of a local 64-bit word memory
// after a fixed initial latency, one registered response beat per cycle.
module cbus_mem_responder #(
    parameter int          MEM_WORDS = 4096,
    parameter int          LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [150:0] creq,
    output logic [65:0]  cresp
);
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {IDLE, WAIT, BEAT, DRAIN} state_t;

    localparam int AW = $clog2(MEM_WORDS);

    cbus_req_t  req;
    cbus_resp_t resp_q;
    state_t     state, state_n;

    logic [63:0]   mem [MEM_WORDS];
    logic [63:0]   cur_addr, nxt_addr, step, window;
    logic [2:0]    size_q;
    logic [7:0]    len_q, beat_cnt;
    logic [1:0]    burst_q;
    logic          wr_q;
    logic [3:0]    lat_cnt;
    logic [AW-1:0] cur_idx, beat_idx;
    logic          accept, issue;

    assign req   = creq;
    assign cresp = resp_q;

    assign cur_idx = AW'((cur_addr - BASE_ADDR) >> 3);
    assign step    = 64'd1 << size_q;
    assign window  = step * (64'(len_q) + 64'd1);

    always_comb begin
        case (burst_q)
            2'd0:    nxt_addr = cur_addr;
            2'd2:    nxt_addr = (cur_addr & ~(window - 64'd1)) |
                                ((cur_addr + step) & (window - 64'd1));
            default: nxt_addr = cur_addr + step;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    // Dropping valid anywhere in a burst abandons it; DRAIN waits for valid low
    // so a request still held high after its last beat is not served twice.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        issue   = 1'b0;
        case (state)
            IDLE: if (req.valid) begin
                accept  = 1'b1;
                state_n = (LATENCY == 0) ? BEAT : WAIT;
            end
            WAIT: begin
                if (!req.valid)        state_n = IDLE;
                else if (lat_cnt == 1) state_n = BEAT;
            end
            BEAT: begin
                if (!req.valid) state_n = IDLE;
                else begin
                    issue = 1'b1;
                    if (beat_cnt == len_q) state_n = DRAIN;
                end
            end
            DRAIN: if (!req.valid) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_q   <= '0;
            cur_addr <= '0;
            size_q   <= '0;
            len_q    <= '0;
            burst_q  <= '0;
            wr_q     <= 1'b0;
            lat_cnt  <= '0;
            beat_cnt <= '0;
            beat_idx <= '0;
        end else begin
            resp_q <= '0;
            if (accept) begin
                cur_addr <= req.addr;
                size_q   <= req.size;
                len_q    <= req.len;
                burst_q  <= req.burst;
                wr_q     <= req.is_write;
                lat_cnt  <= 4'(LATENCY);
                beat_cnt <= '0;
            end
            if (state == WAIT) lat_cnt <= lat_cnt - 4'd1;
            if (issue) begin
                resp_q.ready <= 1'b1;
                resp_q.last  <= (beat_cnt == len_q);
                resp_q.data  <= wr_q ? 64'd0 : mem[cur_idx];
                beat_idx     <= cur_idx;
                beat_cnt     <= beat_cnt + 8'd1;
                cur_addr     <= nxt_addr;
            end
        end
    end

    // Write data is taken in the cycle its beat is presented, so the word index
    // is the one registered alongside ready, not the already-advanced address.
    always_ff @(posedge clk) begin
        if (resp_q.ready && req.valid && wr_q) begin
            for (int i = 0; i < 8; i++)
                if (req.strobe[i]) mem[beat_idx][8*i +: 8] <= req.data[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_cbus_mem_responder.sv
// Randomized scoreboard bench: two responders (latency 2 and 0) checked against
// a word-array model with per-beat data, last flag and arrival cycle.
module tb_cbus_mem_responder;
    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
    localparam int          MW   = 4096;

    typedef struct {
        logic [63:0] data;
        bit          dk;
        bit          last;
        int          cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         resetn;
    logic [150:0] creq  [2];
    logic [65:0]  cresp [2];

    int n_chk = 0, n_pass = 0, cyc = 0;
    exp_t qa[$], qb[$];
    logic [63:0] mdl   [2][MW];
    bit          known [2][MW];
    logic [63:0] wdata [256];
    logic [7:0]  wstrb [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cbus_mem_responder #(.MEM_WORDS(MW), .LATENCY(2), .BASE_ADDR(BASE)) dut_a (
        .clk(clk), .resetn(resetn), .creq(creq[0]), .cresp(cresp[0]));
    cbus_mem_responder #(.MEM_WORDS(MW), .LATENCY(0), .BASE_ADDR(BASE)) dut_b (
        .clk(clk), .resetn(resetn), .creq(creq[1]), .cresp(cresp[1]));

    function automatic int lat(int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic logic [150:0] mk(bit v, bit w, logic [2:0] sz, logic [63:0] a,
                                        logic [7:0] st, logic [63:0] dt, logic [7:0] ln,
                                        logic [1:0] b);
        return {v, w, sz, a, st, dt, ln, b};
    endfunction

    function automatic int idx_of(logic [63:0] a);
        logic [63:0] w;
        w = (a - BASE) / 8;
        return int'(w % MW);
    endfunction

    // Beat k address straight from the burst rules (closed form, not iterated).
    function automatic logic [63:0] addr_k(logic [63:0] a, logic [2:0] sz, logic [7:0] ln,
                                           logic [1:0] b, int k);
        logic [63:0] step, win, lo;
        step = 64'd1 << sz;
        win  = step * (64'(ln) + 64'd1);
        lo   = a - (a % win);
        case (b)
            2'd0:    return a;
            2'd2:    return lo + ((a - lo) + 64'(k) * step) % win;
            default: return a + 64'(k) * step;
        endcase
    endfunction

    task automatic chk(string nm, logic [65:0] act, logic [65:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic mon(int d);
        exp_t e;
        if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
            n_chk++;
            $display("FAIL unexpected_beat dut%0d: ready=1 with data %h at cycle %0d, none expected",
                     d, cresp[d][63:0], cyc);
            return;
        end
        e = (d == 0) ? qa.pop_front() : qb.pop_front();
        if (e.dk) chk($sformatf("beat_data%0d", d), 66'(cresp[d][63:0]), 66'(e.data));
        chk($sformatf("beat_last%0d", d), 66'(cresp[d][64]), 66'(e.last));
        chk($sformatf("beat_cycle%0d", d), 66'(cyc), 66'(e.cyc));
    endtask

    always @(negedge clk) if (cresp[0][65] === 1'b1) mon(0);
    always @(negedge clk) if (cresp[1][65] === 1'b1) mon(1);

    task automatic push_exp(int d, bit w, logic [2:0] sz, logic [63:0] a, logic [7:0] ln,
                            logic [1:0] b, int npres, int acc);
        for (int k = 0; k < npres; k++) begin
            exp_t e;
            int   i;
            i      = idx_of(addr_k(a, sz, ln, b, k));
            e.data = w ? 64'd0 : mdl[d][i];
            e.dk   = w || known[d][i];
            e.last = (k == int'(ln));
            e.cyc  = acc + lat(d) + 1 + k;
            if (d == 0) qa.push_back(e);
            else        qb.push_back(e);
        end
    endtask

    task automatic wait_ready(int d, output bit ok);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (cresp[d][65] !== 1'b1 && t < 24);
        ok = (cresp[d][65] === 1'b1);
        if (!ok) begin
            n_chk++;
            $display("FAIL ready_timeout dut%0d: no ready within %0d cycles at cycle %0d", d, t, cyc);
        end
    endtask

    // abort_after > 0: valid drops once that many beats have completed.
    // hold: cycles valid stays high after the last beat.
    task automatic burst(int d, bit w, logic [2:0] sz, logic [63:0] a, logic [7:0] ln,
                         logic [1:0] b, int abort_after, int hold);
        int nb, npres, acc, ix;
        bit ok;
        nb    = int'(ln) + 1;
        npres = (abort_after > 0 && abort_after < nb) ? abort_after + 1 : nb;
        @(posedge clk); #1;
        acc = cyc + 1;
        push_exp(d, w, sz, a, ln, b, npres, acc);
        creq[d] = mk(1'b1, w, sz, a, wstrb[0], wdata[0], ln, b);
        for (int k = 0; k < nb; k++) begin
            if (abort_after > 0 && k == abort_after) break;
            wait_ready(d, ok);
            if (!ok) break;
            if (w) begin
                ix = idx_of(addr_k(a, sz, ln, b, k));
                for (int i = 0; i < 8; i++)
                    if (wstrb[k][i]) mdl[d][ix][8*i +: 8] = wdata[k][8*i +: 8];
                if (wstrb[k] == 8'hFF) known[d][ix] = 1'b1;
            end
            @(posedge clk); #1;
            if (k + 1 < nb) creq[d] = mk(1'b1, w, sz, a, wstrb[k+1], wdata[k+1], ln, b);
        end
        repeat (hold) @(posedge clk);
        #1 creq[d][150] = 1'b0;
    endtask

    task automatic fill(logic [63:0] first, bit ramp, int n);
        for (int k = 0; k < n; k++) begin
            wdata[k] = ramp ? first + 64'(k) : {$urandom, $urandom};
            wstrb[k] = 8'hFF;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        bit          ok;
        int          acc, nb, ab;
        logic [2:0]  sz;
        logic [7:0]  ln;
        logic [1:0]  b;
        logic [63:0] a, alias_off;
        bit          w;

        creq[0] = '0;
        creq[1] = '0;
        resetn  = 1'b1;
        #2 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_resp_a", cresp[0], 66'd0);
        chk("reset_resp_b", cresp[1], 66'd0);
        resetn = 1'b1;

        // Preload words 0..255 with their index in one MLEN256 burst.
        fill(64'd0, 1'b1, 256);
        burst(0, 1'b1, 3'd3, BASE, 8'd255, 2'd1, 0, 0);

        // Single read with latency 2.
        wdata[0] = 64'hDEAD_BEEF_0123_4567; wstrb[0] = 8'hFF;
        burst(0, 1'b1, 3'd3, BASE, 8'd0, 2'd1, 0, 0);
        burst(0, 1'b0, 3'd3, BASE, 8'd0, 2'd1, 0, 1);
        wdata[0] = 64'd0;
        burst(0, 1'b1, 3'd3, BASE, 8'd0, 2'd1, 0, 0);

        // INCR x16 and WRAP x8 starting at word 5.
        burst(0, 1'b0, 3'd3, BASE, 8'd15, 2'd1, 0, 0);
        burst(0, 1'b0, 3'd3, BASE + 64'h28, 8'd7, 2'd2, 0, 0);

        // Strobed write over a zeroed word, then readback.
        wdata[0] = 64'd0; wstrb[0] = 8'hFF;
        burst(0, 1'b1, 3'd3, BASE + 64'h10, 8'd0, 2'd1, 0, 0);
        wdata[0] = 64'h1122_3344_5566_7788; wstrb[0] = 8'b0000_1100;
        burst(0, 1'b1, 3'd3, BASE + 64'h10, 8'd0, 2'd1, 0, 0);
        burst(0, 1'b0, 3'd3, BASE + 64'h10, 8'd0, 2'd1, 0, 0);

        // Abort an MLEN8 write after 3 beats; readback shows only words 0..2 changed.
        fill(64'd0, 1'b0, 8);
        burst(0, 1'b1, 3'd3, BASE, 8'd7, 2'd1, 3, 0);
        burst(0, 1'b0, 3'd3, BASE, 8'd7, 2'd1, 0, 0);

        // Reset during WAIT: no beat may ever appear.
        @(posedge clk); #1;
        creq[0] = mk(1'b1, 1'b0, 3'd3, BASE, 8'h00, 64'd0, 8'd0, 2'd1);
        @(posedge clk); #2;
        resetn = 1'b0;
        #1 chk("reset_in_wait", cresp[0], 66'd0);
        creq[0][150] = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        repeat (4) @(posedge clk);

        // Reset while a write beat is presented: that beat and the rest are dropped.
        fill(64'd0, 1'b0, 4);
        @(posedge clk); #1;
        acc = cyc + 1;
        push_exp(0, 1'b1, 3'd3, BASE + 64'd800, 8'd3, 2'd1, 1, acc);
        creq[0] = mk(1'b1, 1'b1, 3'd3, BASE + 64'd800, 8'hFF, wdata[0], 8'd3, 2'd1);
        wait_ready(0, ok);
        #1 resetn = 1'b0;
        #1 chk("reset_in_beat", cresp[0], 66'd0);
        creq[0][150] = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        burst(0, 1'b0, 3'd3, BASE + 64'd800, 8'd3, 2'd1, 0, 0);

        // Randomized bursts; addresses may alias one memory size above or below.
        for (int it = 0; it < 48; it++) begin
            w  = 1'($urandom);
            sz = 3'($urandom_range(0, 3));
            b  = 2'($urandom_range(0, 3));
            if (b == 2'd2) ln = 8'((1 << $urandom_range(0, 4)) - 1);
            else           ln = 8'($urandom_range(0, 15));
            case ($urandom_range(0, 2))
                0:       alias_off = 64'd0;
                1:       alias_off = 64'(MW * 8);
                default: alias_off = 64'd0 - 64'(MW * 8);
            endcase
            a  = BASE + 64'($urandom_range(0, 230 * 8)) + alias_off;
            nb = int'(ln) + 1;
            ab = (nb > 1 && $urandom_range(0, 5) == 0) ? $urandom_range(1, nb - 1) : 0;
            for (int k = 0; k < nb; k++) begin
                wdata[k] = {$urandom, $urandom};
                wstrb[k] = 8'($urandom);
            end
            burst(0, w, sz, a, ln, b, ab, (ab > 0) ? 0 : $urandom_range(0, 2));
        end
        burst(0, 1'b0, 3'd3, BASE, 8'd255, 2'd1, 0, 0);

        // Latency 0: valid held across a finished MLEN4 read must not restart it.
        fill(64'h100, 1'b1, 8);
        burst(1, 1'b1, 3'd3, BASE, 8'd7, 2'd1, 0, 0);
        burst(1, 1'b0, 3'd3, BASE, 8'd3, 2'd1, 0, 5);
        burst(1, 1'b0, 3'd3, BASE + 64'd32, 8'd3, 2'd0, 0, 0);
        burst(1, 1'b0, 3'd3, BASE + 64'd8, 8'd3, 2'd2, 0, 0);

        repeat (6) @(posedge clk);
        #1;
        chk("pending_a", 66'(qa.size()), 66'd0);
        chk("pending_b", 66'(qb.size()), 66'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cbus_mem_responder.md
Name: cbus_mem_responder

Overview:
- Worker end of the cache bus: accepts cbus_req_t bursts from an I/D cache miss/writeback engine and answers with cbus_resp_t beats.
- Serves requests from an internal 64-bit word memory with a programmable initial latency.
- Supports FIXED, INCR and WRAP bursts, byte strobes and lengths up to MLEN256.
- Used as the simulation and FPGA-BRAM backing store behind the caches, in place of the AXI bridge.

Parameters:
- MEM_WORDS, 4096, number of 64-bit words; must be a power of 2.
- LATENCY, 2, idle cycles between request acceptance and the first beat; range 0..15.
- BASE_ADDR, 64'h0000_0000_8000_0000, address that maps to word 0 (same as PCINIT).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- resetn  input  1  asynchronous active-low reset.
- creq  input  cbus_req_t (151)  fields: valid, is_write, size, addr, strobe, data, len, burst.
- cresp  output  cbus_resp_t (66)  fields: ready, last, data. All fields are registered.

Behaviour:
- Reset: async on resetn=0. State goes to IDLE; cresp.ready=0, cresp.last=0, cresp.data=0; beat and latency counters go to 0. Memory contents are not reset. A reset mid-burst abandons the burst and no further writes occur.
- Word index: idx = ((addr - BASE_ADDR) >> 3) mod MEM_WORDS. Out-of-range addresses wrap silently and produce no error.
- FSM states: IDLE, WAIT, BEAT, DRAIN.
- IDLE, on creq.valid=1:
  - Latch addr, size, len, burst and is_write.
  - Load lat_cnt=LATENCY and beat_cnt=0.
  - Next state is WAIT, or BEAT if LATENCY=0.
- WAIT: lat_cnt decrements each cycle; when lat_cnt reaches 1, go to BEAT. The first cresp.ready=1 appears exactly LATENCY+1 cycles after the IDLE acceptance edge.
- BEAT, one beat per cycle with no bubbles:
  - The registered cresp.ready=1 is asserted for beats 0..len.
  - Read: cresp.data = mem[idx(cur_addr)], the full aligned 64-bit word regardless of size.
  - Write: cresp.data=0. On each cycle where cresp.ready=1 and creq.valid=1, mem[idx] is byte-written with creq.data where creq.strobe[i]=1. The master holds beat data stable until it samples ready.
  - cresp.last=1 together with ready on beat beat_cnt==len; for MLEN1, last=1 on the single beat.
  - After the last beat, ready and last drop to 0 on the next cycle and the state goes to DRAIN.
- Address advance per beat, with step = 1 << size:
  - FIXED: address unchanged.
  - INCR and RESERVED: cur_addr += step.
  - WRAP: window = step * (len+1), aligned to window. cur_addr = (cur_addr & ~(window-1)) | ((cur_addr + step) & (window-1)).
- DRAIN: stay until creq.valid=0, then go to IDLE. This prevents a still-asserted valid from being re-accepted. A new request may be accepted in the cycle after valid has been seen low.
- Abort: if creq.valid drops in WAIT or BEAT, the next state is IDLE and ready/last are cleared next cycle. A write beat whose valid is 0 is not performed.
- Simultaneous events: reset dominates everything. A write and a read of the same word never coexist, since only one burst is in flight at a time.
- Arithmetic: beat_cnt is 8 bits and compared against len (mlen_t). Address arithmetic is 64-bit modulo 2^64.

Test Plan:
- Single read: preload mem[0]=64'hDEAD_BEEF_0123_4567; LATENCY=2; creq valid, addr=0x8000_0000, len=MLEN1, INCR, accepted at cycle 0. Expect ready=last=1 only at cycle 3 with that data, then DRAIN, then IDLE after valid drops.
- INCR burst: preload words 0..15 with value=index; read addr=0x8000_0000, len=MLEN16, size=MSIZE8. Expect 16 consecutive ready cycles with data 0..15 and last only on data=15.
- WRAP burst: read addr=0x8000_0028, len=MLEN8, size=MSIZE8. Expect word order 5,6,7,0,1,2,3,4, with last on word 4.
- Strobed write then readback: write addr=0x8000_0010, len=MLEN1, data=64'h1122_3344_5566_7788, strobe=8'b0000_1100 over an old value of 0. Reading it back gives 64'h0000_0000_5566_0000.
- Abort and reset: deassert valid after 3 beats of an MLEN8 write; expect only words 0..2 modified and IDLE next cycle. Separately, assert resetn=0 mid-WAIT; expect ready=0 immediately (async) and no beat issued.
- Back-to-back with LATENCY=0: keep valid high across a finished MLEN4 read. Expect no second burst until valid goes low for at least 1 cycle; the next request's first beat arrives 1 cycle after its acceptance.
